// File: rtl/tff_bank_sequencer.sv
// Sequencer for a bank of WIDTH toggle flip-flops: count up/down, load or clear by toggling only.
// Optional macro TFF_GRAY_EN switches counting ops to reflected Gray code via a binary shadow counter.
module tff_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {IDLE, RUN, APPLY, DONE} state_t;

    localparam logic [WIDTH-1:0] MAXV  = '1;
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ONE_L = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             op_lsb;     // 1 = count-down / clear
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt;
    logic             fin;
    logic             wrap_arm;

    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] step_t;
    logic [WIDTH-1:0] apply_t;
    logic             step_wrap;

`ifdef TFF_GRAY_EN
    logic [WIDTH-1:0] b;

    function automatic logic [WIDTH-1:0] gray_enc(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray_dec(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction
`endif

    // t_vec is already committed, so the next step is computed from the state q will hold after this edge
    assign qn = q ^ t_vec;

    always_comb begin
`ifdef TFF_GRAY_EN
        cur    = b;
        nxt    = op_lsb ? (cur - ONE_W) : (cur + ONE_W);
        step_t = qn ^ gray_enc(nxt);
`else
        cur    = qn;
        nxt    = op_lsb ? (cur - ONE_W) : (cur + ONE_W);
        step_t = qn ^ nxt;
`endif
        step_wrap = op_lsb ? (cur == '0) : (cur == MAXV);
        apply_t   = op_lsb ? qn : (qn ^ data_r);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            wrap_arm  <= 1'b0;
            q         <= '0;
            t_vec     <= '0;
            op_lsb    <= 1'b0;
            data_r    <= '0;
            len_r     <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
`ifdef TFF_GRAY_EN
            b         <= '0;
`endif
        end else begin
            q        <= qn;
            t_vec    <= '0;
            done     <= 1'b0;
            wrap     <= wrap_arm;
            wrap_arm <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_lsb    <= cmd_op[0];
                        data_r    <= cmd_data;
                        len_r     <= cmd_len;
                        cnt       <= '0;
                        fin       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= cmd_op[1] ? APPLY : RUN;
                    end
                end
                RUN: begin
                    // fin marks that the last step's toggle is being applied on this edge
                    if (fin) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        t_vec    <= step_t;
                        wrap_arm <= step_wrap;
                        cnt      <= cnt + ONE_L;
                        fin      <= (cnt == len_r);
`ifdef TFF_GRAY_EN
                        b        <= nxt;
`endif
                    end
                end
                APPLY: begin
                    if (fin) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        t_vec <= apply_t;
                        fin   <= 1'b1;
`ifdef TFF_GRAY_EN
                        b     <= op_lsb ? '0 : gray_dec(data_r);
`endif
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tff_bank_sequencer.md
Name: tff_bank_sequencer

Overview:
- Controller for a bank of WIDTH toggle flip-flops. Every cycle it computes the per-bit toggle vector so the bank counts up, counts down, loads a value or clears, by toggling bits only.
- Commands arrive over a valid/ready handshake. Each command runs for a programmed number of steps, then the block reports completion.
- Sits between a control/CSR source and any logic that consumes toggle-based counter state.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank (2..16).
- LEN_W, 4, width of the step-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (1 only in IDLE).
- cmd_op  input  2  00 count-up, 01 count-down, 10 load, 11 clear.
- cmd_data  input  WIDTH  load value, used for op 10 only.
- cmd_len  input  LEN_W  number of count steps for ops 00/01; 0 means one step.
- t_vec  output  WIDTH  toggle vector applied to the bank this cycle (registered view).
- q  output  WIDTH  current bank state.
- busy  output  1  FSM is not in IDLE.
- done  output  1  one-cycle pulse when a command completes.
- wrap  output  1  one-cycle pulse when a count step wraps (max to 0 up, 0 to max down).

Behaviour:
- Bank: WIDTH T flip-flops. On each clk edge, bit i becomes q[i]^t[i]. t is 0 outside RUN/APPLY, so the bank holds.
- Reset (rst=0, async): q=0, t_vec=0, FSM=IDLE, cmd_ready=1, busy=0, done=0, wrap=0, step counter=0.
- FSM states:
  - IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) on edge k latches op, data and len.
    - Op 00/01 go to RUN.
    - Op 10/11 go to APPLY.
    - cmd_valid while not in IDLE is ignored; no queuing. Source must hold valid until ready.
  - RUN: one count step per cycle.
    - Up: t = q ^ (q+1) mod 2^WIDTH.
    - Down: t = q ^ (q-1) mod 2^WIDTH.
    - Step counter starts at 0. After the step where counter==len, go to DONE. The command therefore performs len+1 steps.
  - APPLY: single cycle.
    - Load: t = q ^ cmd_data.
    - Clear: t = q.
    - Then go to DONE.
  - DONE: done=1 for exactly one cycle, t=0, then IDLE. cmd_ready is 0 in DONE.
- Latency: a command accepted at edge k gives its first q change at edge k+2 (edge k+1 enters RUN/APPLY and registers t; the bank toggles on the next edge). done is high in the cycle after the final toggle.
- Arithmetic: all count arithmetic is modulo 2^WIDTH, with no saturation.
- wrap: pulses in the cycle the wrapping toggle takes effect (q goes max to 0 up, or 0 to max down).
- t_vec shows the toggle vector applied at the next edge; it is 0 in IDLE and DONE.
- Load of a value equal to q: t=0, and done still pulses.
- cmd_len at maximum (2^LEN_W-1): 2^LEN_W steps, no counter overflow.
- Reset asserted mid-RUN: the command is abandoned, no done pulse, q=0.

Optional Feature:
- Macro: TFF_GRAY_EN.
- Defined: counting ops step through reflected Gray code. A hidden binary shadow counter b steps by ±1 and q tracks gray(b) = b^(b>>1), so exactly one t bit is set per step.
  - Load and clear also set the shadow to gray-decode(cmd_data) or 0.
  - wrap fires when b wraps.
- Undefined: plain binary counting as above, with no shadow register.

Test Plan:
- Reset: rst=0 mid-simulation while q=5 -> q=0, cmd_ready=1, busy=0, done=0 without waiting for clk.
- Count-up: WIDTH=4, q=0, op=00, len=3 -> q sequence 1,2,3,4; t_vec 0001,0011,0001,0111; one done pulse; busy deasserts after.
- Wrap down: load 0 then op=01, len=1 -> q=15 then 14; wrap pulses once on 0 to 15; done once.
- Load/clear: q=3, load 1010 -> t_vec=1001, q=1010, done; then clear -> t_vec=1010, q=0.
- Handshake: cmd_valid held high across back-to-back commands -> second command is accepted only at the first IDLE edge after done; a command issued while busy is not executed.
- TFF_GRAY_EN: op=00, len=7 from 0 -> q 0001,0011,0010,0110,0111,0101,0100,1100; popcount(t_vec)=1 every step.
